uart_rx_deserializer: RTL and testbench

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_deserializer_if.sv | 23 ++
 rtl/uart_bit_timer.sv | 56 +++++
 rtl/uart_rx_deserializer.sv | 68 ++++++
 tb/tb_uart_rx_deserializer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
// The serial frame is one start bit, eight data bits sent LSB first, and one stop bit.
package uart_rx_pkg;

  localparam int        OVERSAMPLE = 16;
  localparam int        MID_SAMPLE = 7;
  localparam int        FRAME_BITS = 10;
  localparam logic [3:0] BIC_DONE  = 4'd10;

  typedef logic [3:0]            bsc_t;
  typedef logic [3:0]            bic_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  // A frame is bad if the start bit was sampled high or the stop bit was sampled low.
  function automatic logic frame_error(input frame_t f);
    return f[0] | ~f[FRAME_BITS-1];
  endfunction

  function automatic logic [7:0] frame_char(input frame_t f);
    return f[8:1];
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Frame-level signals exchanged between the start-bit detector and the deserializer.
// The master drives the frame; the slave reports the bit index and the received character.
interface uart_rx_deserializer_if;
  import uart_rx_pkg::*;

  logic       enable;
  logic       data_in;
  bic_t       bic;
  logic [7:0] data_out;
  logic       char_valid;
  logic       frame_err;

  modport master (
    output enable, data_in,
    input  bic, data_out, char_valid, frame_err
  );

  modport slave (
    input  enable, data_in,
    output bic, data_out, char_valid, frame_err
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Oversample counter (BSC) and bit index counter (bic) for one received frame.
// Emits a mid-bit sample strobe and a strobe on the clock where bic steps from 9 to 10.
module uart_bit_timer #(
  parameter int OVERSAMPLE = uart_rx_pkg::OVERSAMPLE,
  parameter int MID_SAMPLE = uart_rx_pkg::MID_SAMPLE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  output uart_rx_pkg::bic_t bic_o,
  output logic              sample_o,
  output logic              done_o
);
  import uart_rx_pkg::*;

  localparam bsc_t BSC_LAST = bsc_t'(OVERSAMPLE - 1);
  localparam bsc_t BSC_MID  = bsc_t'(MID_SAMPLE);
  localparam bic_t BIC_LAST = BIC_DONE - 4'd1;

  bsc_t bsc_q, bsc_d;
  bic_t bic_q, bic_d;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    bsc_d = bsc_q;
    bic_d = bic_q;
    if (!enable_i) begin
      bsc_d = '0;
      bic_d = '0;
    end else if (bic_q != BIC_DONE) begin
      // Once bic reaches 10 both counters freeze until enable drops.
      if (bsc_q == BSC_LAST) begin
        bsc_d = '0;
        bic_d = bic_q + 4'd1;
      end else begin
        bsc_d = bsc_q + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bsc_q <= '0;
      bic_q <= '0;
    end else begin
      bsc_q <= bsc_d;
      bic_q <= bic_d;
    end
  end

  assign bic_o    = bic_q;
  assign sample_o = enable_i && (bic_q != BIC_DONE) && (bsc_q == BSC_MID);
  assign done_o   = enable_i && (bic_q == BIC_LAST) && (bsc_q == BSC_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// Collects ten mid-bit samples into a shift register and publishes the character
// with a framing-error flag and a one-cycle char_valid pulse at the end of each frame.
module uart_rx_deserializer #(
  parameter int OVERSAMPLE = uart_rx_pkg::OVERSAMPLE,
  parameter int MID_SAMPLE = uart_rx_pkg::MID_SAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_rx_deserializer_if.slave rx
);
  import uart_rx_pkg::*;

  bic_t       bic;
  logic       sample_stb;
  logic       done_stb;

  frame_t     sr_q, sr_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;
  logic       valid_q;

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE),
    .MID_SAMPLE (MID_SAMPLE)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .enable_i (rx.enable),
    .bic_o    (bic),
    .sample_o (sample_stb),
    .done_o   (done_stb)
  );

  // New samples enter at the top, so after ten shifts the start bit sits in sr[0].
  always_comb begin
    sr_d   = sr_q;
    data_d = data_q;
    err_d  = err_q;
    if (sample_stb) begin
      sr_d = {rx.data_in, sr_q[FRAME_BITS-1:1]};
    end
    if (done_stb) begin
      data_d = frame_char(sr_q);
      err_d  = frame_error(sr_q);
    end
  end

  // NOTE: the shift register is ordinary flops, not a memory, so it is cleared with the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= done_stb;
    end
  end

  assign rx.bic        = bic;
  assign rx.data_out   = data_q;
  assign rx.frame_err  = err_q;
  assign rx.char_valid = valid_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: frame-level reference model plus scoreboard of intended characters,
// directed corner cases and randomized frames with noise between sample points.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int OS      = 16;
  localparam int LATENCY = 10 * OS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_deserializer_if rx_if ();

  uart_rx_deserializer #(
    .OVERSAMPLE (16),
    .MID_SAMPLE (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: count consecutive enabled edges; sample at the middle of each bit
  // period; after ten bit periods publish the character.
  int         cyc     = 0;
  int         run_len = 0;
  bit         started = 1'b0;
  logic [9:0] m_samp  = '0;
  logic       m_cv    = 1'b0;
  logic [7:0] m_data  = '0;
  logic       m_err   = 1'b0;

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    m_cv    = 1'b0;
    if (reset) begin
      run_len = 0;
      m_data  = '0;
      m_err   = 1'b0;
    end else if (!rx_if.enable) begin
      run_len = 0;
    end else begin
      if (run_len < LATENCY && (run_len % OS) == OS / 2 - 1)
        m_samp[run_len / OS] = rx_if.data_in;
      if (run_len == LATENCY - 1) begin
        m_cv   = 1'b1;
        m_data = m_samp[8:1];
        m_err  = m_samp[0] | ~m_samp[9];
      end
      if (run_len < LATENCY) run_len++;
    end
  end

  // Intended characters {frame_err, data} pushed by the stimulus for every complete frame.
  logic [8:0] exp_q[$];
  int         pulse_cycs[$];

  always @(negedge clk) begin
    if (started) begin
      check("char_valid", rx_if.char_valid, m_cv);
      check("data_out",   rx_if.data_out,   m_data);
      check("frame_err",  rx_if.frame_err,  m_err);
      check("bic",        rx_if.bic,        run_len / OS);
      if (rx_if.char_valid) begin
        pulse_cycs.push_back(cyc);
        check("pulse has queued frame", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("scoreboard data_out",  rx_if.data_out,  e[7:0]);
          check("scoreboard frame_err", rx_if.frame_err, e[8]);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_if.enable  = 1'b0;
      rx_if.data_in = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // bits[0]=start, bits[8:1]=data, bits[9]=stop. Reset is pulsed on edge rst_at if >= 0.
  task automatic send_frame(input logic [9:0] bits, input int n_edges, input bit noise,
                            input int rst_at);
    if (n_edges >= LATENCY && rst_at < 0)
      exp_q.push_back({bits[0] | ~bits[9], bits[8:1]});
    for (int k = 0; k < n_edges; k++) begin
      rx_if.enable = 1'b1;
      if (k >= LATENCY)
        rx_if.data_in = 1'b1;
      else if (noise && (k % OS) != OS / 2 - 1)
        rx_if.data_in = 1'($urandom);
      else
        rx_if.data_in = bits[k / OS];
      reset = (k == rst_at);
      @(posedge clk); #1;
    end
    reset         = 1'b0;
    rx_if.enable  = 1'b0;
    rx_if.data_in = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset         = 1'b1;
    rx_if.enable  = 1'b0;
    rx_if.data_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset char_valid", rx_if.char_valid, 0);
    check("reset data_out",   rx_if.data_out,   0);
    check("reset frame_err",  rx_if.frame_err,  0);
    check("reset bic",        rx_if.bic,        0);
    reset = 1'b0;
    idle(2);

    // Clean frame 0xA5.
    t0 = cyc;
    send_frame({1'b1, 8'hA5, 1'b0}, LATENCY, 1'b0, -1);
    check("A5 char_valid", rx_if.char_valid, 1);
    check("A5 data_out",   rx_if.data_out,   8'hA5);
    check("A5 frame_err",  rx_if.frame_err,  0);
    idle(1);
    check("A5 pulse width", rx_if.char_valid, 0);
    check("A5 latency", pulse_cycs[$] - t0, LATENCY);
    idle(3);

    // Back-to-back frames 0x00 then 0xFF, enable re-raised one clock after bic=10.
    send_frame({1'b1, 8'h00, 1'b0}, LATENCY, 1'b0, -1);
    check("b2b first data_out", rx_if.data_out, 8'h00);
    idle(1);
    send_frame({1'b1, 8'hFF, 1'b0}, LATENCY, 1'b0, -1);
    check("b2b second data_out",  rx_if.data_out,  8'hFF);
    check("b2b second frame_err", rx_if.frame_err, 0);
    idle(1);
    check("b2b pulse spacing", pulse_cycs[$] - pulse_cycs[$-1], 161);

    // Abort at bic=4: partial frame discarded.
    send_frame({1'b1, 8'h96, 1'b0}, 4 * OS + 3, 1'b1, -1);
    check("abort bic before drop", rx_if.bic, 4);
    idle(1);
    check("abort bic cleared",  rx_if.bic,        0);
    check("abort data kept",    rx_if.data_out,   8'hFF);
    check("abort no pulse",     rx_if.char_valid, 0);

    // Bad stop bit, started straight after the abort (fresh BSC).
    send_frame({1'b0, 8'h3C, 1'b0}, LATENCY, 1'b1, -1);
    check("bad stop data_out",  rx_if.data_out,  8'h3C);
    check("bad stop frame_err", rx_if.frame_err, 1);
    idle(2);

    // False start: start bit sampled high.
    send_frame({1'b1, 8'h5A, 1'b1}, LATENCY, 1'b1, -1);
    check("false start data_out",  rx_if.data_out,  8'h5A);
    check("false start frame_err", rx_if.frame_err, 1);
    idle(2);

    // Reset pulsed at bic=6.
    send_frame({1'b1, 8'h11, 1'b0}, 6 * OS + 4, 1'b1, 6 * OS + 4 - 1);
    check("mid reset data_out",   rx_if.data_out,   0);
    check("mid reset frame_err",  rx_if.frame_err,  0);
    check("mid reset char_valid", rx_if.char_valid, 0);
    check("mid reset bic",        rx_if.bic,        0);
    idle(2);

    // Randomized frames: mostly complete, some held long at bic=10, some aborted.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic       st, sp;
      int         r, n;
      b  = 8'($urandom);
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 7) != 0);
      r  = $urandom_range(0, 9);
      if (r < 6)      n = LATENCY;
      else if (r < 8) n = LATENCY + $urandom_range(1, 40);
      else            n = $urandom_range(1, LATENCY - 1);
      send_frame({sp, b, st}, n, 1'b1, -1);
      idle($urandom_range(1, 4));
    end

    idle(4);
    check("all frames delivered", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
